// File: rtl/sprite_pkg.sv
// Shared constants for the sprite register bank: field layout, status window map,
// and the player rotation encoding.
package sprite_pkg;

   localparam int FIELDS_PER_SPRITE = 3;
   localparam int FLD_X   = 0;
   localparam int FLD_Y   = 1;
   localparam int FLD_ROT = 2;

   localparam int ST_MAP   = 0;
   localparam int ST_ROT   = 1;
   localparam int ST_FRAME = 2;
   localparam int ST_DROP  = 3;
   localparam int ST_PEND  = 4;

   localparam logic [1:0] ROT_RIGHT = 2'd0;
   localparam logic [1:0] ROT_UP    = 2'd1;
   localparam logic [1:0] ROT_LEFT  = 2'd2;
   localparam logic [1:0] ROT_DOWN  = 2'd3;

   function automatic int field_addr(input int sprite, input int fld);
      return sprite * FIELDS_PER_SPRITE + fld;
   endfunction

endpackage

// File: rtl/sprite_bank_cell.sv
// One double-buffered register: the CPU-facing shadow copy and the renderer-facing
// active copy. A commit copies the pre-write shadow value into active.
module sprite_bank_cell #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic              commit,
   output logic [DATA_W-1:0] shadow,
   output logic [DATA_W-1:0] active
);

   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [DATA_W-1:0] active_q, active_d;

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (we) shadow_d = wdata;
      if (commit) active_d = shadow_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign shadow = shadow_q;
   assign active = active_q;

endmodule

// File: rtl/sprite_reg_bank.sv
// Double-buffered sprite/world register file between the game CPU and the renderer,
// with a read-only status window in the upper half of the CPU address space.
module sprite_reg_bank
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 5,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 6,
   parameter int CNT_W       = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [ADDR_W-1:0]              reg_addr,
   input  logic [DATA_W-1:0]              in,
   input  logic                           we,
   output logic [DATA_W-1:0]              out,
   input  logic                           mapData,
   input  logic [1:0]                     playerRot,
   input  logic                           vblank,
   input  logic                           disp_req,
   input  logic [$clog2(NUM_SPRITES)-1:0] disp_idx,
   output logic                           disp_valid,
   output logic [DATA_W-1:0]              disp_x,
   output logic [DATA_W-1:0]              disp_y,
   output logic [DATA_W-1:0]              disp_rot,
   output logic [DATA_W-1:0]              map_x,
   output logic [DATA_W-1:0]              map_y,
   output logic                           committed
);

   localparam int R        = NUM_SPRITES * FIELDS_PER_SPRITE;
   localparam int NUM_REGS = R + 2;
   localparam int WD_ADDR  = R + 2;
   localparam int OFF_W    = ADDR_W - 1;
   localparam int IDX_W    = $clog2(NUM_SPRITES);

   logic              status_sel;
   logic [OFF_W-1:0]  offset;
   logic              commit, drop, wd_write;
   logic [NUM_REGS-1:0] cell_we;
   logic [DATA_W-1:0] shadow_bank [NUM_REGS];
   logic [DATA_W-1:0] active_bank [NUM_REGS];

   logic              work_done_q, work_done_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic              committed_q, committed_d;
   logic              disp_valid_q, disp_valid_d;
   logic [DATA_W-1:0] disp_x_q, disp_x_d;
   logic [DATA_W-1:0] disp_y_q, disp_y_d;
   logic [DATA_W-1:0] disp_rot_q, disp_rot_d;

   assign status_sel = reg_addr[ADDR_W-1];
   assign offset     = reg_addr[OFF_W-1:0];
   assign commit     = vblank & work_done_q;
   assign drop       = vblank & ~work_done_q;
   assign wd_write   = we & ~status_sel & (offset == OFF_W'(WD_ADDR));

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      assign cell_we[g] = we & ~status_sel & (offset == OFF_W'(g));
      sprite_bank_cell #(.DATA_W(DATA_W)) u_cell (
         .clk    (clk),
         .reset  (reset),
         .we     (cell_we[g]),
         .wdata  (in),
         .commit (commit),
         .shadow (shadow_bank[g]),
         .active (active_bank[g])
      );
   end

   // A CPU write to work_done lands after the commit clear, so writing 0 on a
   // commit cycle leaves 0 and writing 1 on a vblank cycle only counts next frame.
   always_comb begin
      work_done_d = work_done_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      committed_d = commit;
      if (commit) begin
         work_done_d = 1'b0;
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
      if (wd_write) work_done_d = in[0];
   end

   always_comb begin
      disp_valid_d = disp_req;
      disp_x_d     = disp_x_q;
      disp_y_d     = disp_y_q;
      disp_rot_d   = disp_rot_q;
      if (disp_req) begin
         disp_x_d   = '0;
         disp_y_d   = '0;
         disp_rot_d = '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (disp_idx == IDX_W'(i)) begin
               disp_x_d   = active_bank[field_addr(i, FLD_X)];
               disp_y_d   = active_bank[field_addr(i, FLD_Y)];
               disp_rot_d = active_bank[field_addr(i, FLD_ROT)];
            end
         end
      end
   end

   always_comb begin
      out = '0;
      if (!status_sel) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (offset == OFF_W'(i)) out = shadow_bank[i];
         end
         if (offset == OFF_W'(WD_ADDR)) out = {{(DATA_W-1){1'b0}}, work_done_q};
      end else begin
         if (offset == OFF_W'(ST_MAP))   out = {{(DATA_W-1){1'b0}}, mapData};
         if (offset == OFF_W'(ST_ROT))   out = {{(DATA_W-2){1'b0}}, playerRot};
         if (offset == OFF_W'(ST_FRAME)) out = DATA_W'(frame_cnt_q);
         if (offset == OFF_W'(ST_DROP))  out = DATA_W'(drop_cnt_q);
         if (offset == OFF_W'(ST_PEND))  out = {{(DATA_W-1){1'b0}}, work_done_q};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         work_done_q  <= 1'b0;
         frame_cnt_q  <= '0;
         drop_cnt_q   <= '0;
         committed_q  <= 1'b0;
         disp_valid_q <= 1'b0;
         disp_x_q     <= '0;
         disp_y_q     <= '0;
         disp_rot_q   <= '0;
      end else begin
         work_done_q  <= work_done_d;
         frame_cnt_q  <= frame_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         committed_q  <= committed_d;
         disp_valid_q <= disp_valid_d;
         disp_x_q     <= disp_x_d;
         disp_y_q     <= disp_y_d;
         disp_rot_q   <= disp_rot_d;
      end
   end

   assign disp_valid = disp_valid_q;
   assign disp_x     = disp_x_q;
   assign disp_y     = disp_y_q;
   assign disp_rot   = disp_rot_q;
   assign committed  = committed_q;
   assign map_x      = active_bank[R];
   assign map_y      = active_bank[R+1];

endmodule

// File: tb/tb_sprite_reg_bank.sv
// Self-checking bench for sprite_reg_bank: vector table, directed corner sequences,
// and a randomized run against a frame-level reference model.
module tb_sprite_reg_bank;
   import sprite_pkg::*;

   localparam int NS = 5;
   localparam int NR = NS * 3 + 2;
   localparam int R  = NS * 3;
   localparam int IW = $clog2(NS);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    reg_addr = '0;
   logic [7:0]    in_data = '0;
   logic          we = 1'b0;
   logic [7:0]    out_data;
   logic          mapData = 1'b0;
   logic [1:0]    playerRot = '0;
   logic          vblank = 1'b0;
   logic          disp_req = 1'b0;
   logic [IW-1:0] disp_idx = '0;
   logic          disp_valid;
   logic [7:0]    disp_x, disp_y, disp_rot, map_x, map_y;
   logic          committed;

   int checks = 0;
   int errors = 0;

   logic [7:0] mShadow [NR];
   logic [7:0] mActive [NR];
   logic       mWd, mCommitted, mValid;
   logic [7:0] mFrame, mDrop, mDx, mDy, mDrot;

   typedef struct {
      logic       wr;
      logic [5:0] addr;
      logic [7:0] data;
      logic       mapd;
      logic [1:0] rot;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   sprite_reg_bank #(.NUM_SPRITES(NS), .DATA_W(8), .ADDR_W(6), .CNT_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .reg_addr   (reg_addr),
      .in         (in_data),
      .we         (we),
      .out        (out_data),
      .mapData    (mapData),
      .playerRot  (playerRot),
      .vblank     (vblank),
      .disp_req   (disp_req),
      .disp_idx   (disp_idx),
      .disp_valid (disp_valid),
      .disp_x     (disp_x),
      .disp_y     (disp_y),
      .disp_rot   (disp_rot),
      .map_x      (map_x),
      .map_y      (map_y),
      .committed  (committed)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] expRead(input logic [5:0] addr);
      int off = int'(addr[4:0]);
      if (!addr[5]) begin
         if (off < NR) return mShadow[off];
         if (off == R + 2) return {7'd0, mWd};
         return 8'h00;
      end
      case (off)
         0: return {7'd0, mapData};
         1: return {6'd0, playerRot};
         2: return mFrame;
         3: return mDrop;
         4: return {7'd0, mWd};
         default: return 8'h00;
      endcase
   endfunction

   // Advance one clock: the model evaluates a whole frame-level step from the
   // inputs held across the edge, then the DUT is sampled 1 time unit later.
   task automatic applyStimulus();
      logic [7:0] nShadow [NR];
      logic [7:0] nActive [NR];
      logic       nWd, nCommitted, nValid;
      logic [7:0] nFrame, nDrop, nDx, nDy, nDrot;
      int         off = int'(reg_addr[4:0]);
      int         idx = int'(disp_idx);
      bit         wr0 = we && !reg_addr[5];
      if (reset) begin
         foreach (nShadow[i]) begin
            nShadow[i] = 8'h00;
            nActive[i] = 8'h00;
         end
         nWd = 0; nCommitted = 0; nValid = 0;
         nFrame = 0; nDrop = 0; nDx = 0; nDy = 0; nDrot = 0;
      end else begin
         nShadow = mShadow;
         nActive = mActive;
         if (wr0 && off < NR) nShadow[off] = in_data;
         nWd = mWd; nFrame = mFrame; nDrop = mDrop;
         nCommitted = vblank && mWd;
         if (vblank && mWd) begin
            nActive = mShadow;
            nFrame  = mFrame + 8'd1;
            nWd     = 1'b0;
         end else if (vblank) begin
            nDrop = (mDrop == 8'hFF) ? 8'hFF : mDrop + 8'd1;
         end
         if (wr0 && off == R + 2) nWd = in_data[0];
         nValid = disp_req;
         nDx = mDx; nDy = mDy; nDrot = mDrot;
         if (disp_req) begin
            if (idx < NS) begin
               nDx   = mActive[3*idx + FLD_X];
               nDy   = mActive[3*idx + FLD_Y];
               nDrot = mActive[3*idx + FLD_ROT];
            end else begin
               nDx = 0; nDy = 0; nDrot = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      mShadow = nShadow; mActive = nActive; mWd = nWd; mCommitted = nCommitted;
      mValid = nValid; mFrame = nFrame; mDrop = nDrop;
      mDx = nDx; mDy = nDy; mDrot = nDrot;
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, " disp_valid"}, disp_valid, mValid);
      checkOutput({tag, " disp_x"}, disp_x, mDx);
      checkOutput({tag, " disp_y"}, disp_y, mDy);
      checkOutput({tag, " disp_rot"}, disp_rot, mDrot);
      checkOutput({tag, " committed"}, committed, mCommitted);
      checkOutput({tag, " map_x"}, map_x, mActive[R]);
      checkOutput({tag, " map_y"}, map_y, mActive[R+1]);
   endtask

   task automatic readCheck(input string name, input logic [5:0] addr, input logic [7:0] exp);
      reg_addr = addr;
      #1;
      checkOutput(name, out_data, exp);
   endtask

   task automatic doWrite(input logic [5:0] addr, input logic [7:0] data);
      reg_addr = addr; in_data = data; we = 1'b1;
      applyStimulus();
      we = 1'b0;
   endtask

   task automatic doVblank();
      vblank = 1'b1;
      applyStimulus();
      vblank = 1'b0;
   endtask

   task automatic doDisp(input int idx);
      disp_idx = IW'(idx); disp_req = 1'b1;
      applyStimulus();
      disp_req = 1'b0;
   endtask

   initial begin
      // Reset and the vector table
      reset = 1'b1;
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      for (int a = 0; a < 64; a++) readCheck($sformatf("reset read %0d", a), 6'(a), 8'h00);
      checkOutput("reset disp_valid", disp_valid, 1'b0);
      checkOutput("reset committed", committed, 1'b0);
      checkOutput("reset map_x", map_x, 8'h00);

      vecs.push_back('{1'b0, 6'd32, 8'h00, 1'b1, 2'd0,     8'h01});
      vecs.push_back('{1'b0, 6'd32, 8'h00, 1'b0, 2'd0,     8'h00});
      vecs.push_back('{1'b0, 6'd33, 8'h00, 1'b0, ROT_LEFT, 8'h02});
      vecs.push_back('{1'b0, 6'd33, 8'h00, 1'b0, ROT_DOWN, 8'h03});
      vecs.push_back('{1'b0, 6'd37, 8'h00, 1'b1, 2'd3,     8'h00});
      vecs.push_back('{1'b0, 6'd63, 8'h00, 1'b1, 2'd3,     8'h00});
      vecs.push_back('{1'b1, 6'd0,  8'h05, 1'b0, 2'd0,     8'h05});
      vecs.push_back('{1'b1, 6'd1,  8'hA1, 1'b0, 2'd0,     8'hA1});
      vecs.push_back('{1'b1, 6'd14, 8'h3C, 1'b0, 2'd0,     8'h3C});
      vecs.push_back('{1'b1, 6'd15, 8'h77, 1'b0, 2'd0,     8'h77});
      vecs.push_back('{1'b1, 6'd16, 8'h88, 1'b0, 2'd0,     8'h88});
      vecs.push_back('{1'b1, 6'd18, 8'hFF, 1'b0, 2'd0,     8'h00});
      vecs.push_back('{1'b1, 6'd31, 8'h12, 1'b0, 2'd0,     8'h00});
      vecs.push_back('{1'b1, 6'd33, 8'h55, 1'b0, 2'd0,     8'h00});
      vecs.push_back('{1'b1, 6'd34, 8'h55, 1'b0, 2'd0,     8'h00});
      foreach (vecs[i]) begin
         mapData = vecs[i].mapd;
         playerRot = vecs[i].rot;
         if (vecs[i].wr) doWrite(vecs[i].addr, vecs[i].data);
         readCheck($sformatf("vector %0d addr %0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
      end
      mapData = 1'b0;
      playerRot = 2'd0;
      checkOutput("no commit yet map_x", map_x, 8'h00);

      // Dropped frame leaves active untouched
      doWrite(6'd6, 8'h40);
      readCheck("shadow x2", 6'd6, 8'h40);
      doVblank();
      checkOutput("drop committed", committed, 1'b0);
      doDisp(2);
      checkOutput("drop disp_valid", disp_valid, 1'b1);
      checkOutput("drop disp_x", disp_x, 8'h00);
      readCheck("drop_cnt 1", 6'd35, 8'h01);

      // Commit, with a renderer read on the commit cycle seeing pre-commit data
      doWrite(6'd17, 8'h01);
      readCheck("pending set", 6'd36, 8'h01);
      vblank = 1'b1; disp_idx = IW'(2); disp_req = 1'b1;
      applyStimulus();
      vblank = 1'b0;
      checkOutput("commit pulse", committed, 1'b1);
      checkOutput("commit-cycle disp_x", disp_x, 8'h00);
      readCheck("pending clear", 6'd36, 8'h00);
      readCheck("frame_cnt 1", 6'd34, 8'h01);
      checkOutput("map_x committed", map_x, 8'h77);
      checkOutput("map_y committed", map_y, 8'h88);
      applyStimulus();
      disp_req = 1'b0;
      checkOutput("post-commit disp_x", disp_x, 8'h40);
      checkOutput("post-commit disp_valid", disp_valid, 1'b1);
      checkOutput("committed one cycle", committed, 1'b0);
      applyStimulus();
      checkOutput("idle disp_valid", disp_valid, 1'b0);
      checkOutput("disp_x hold", disp_x, 8'h40);

      // Write racing a commit
      doWrite(6'd0, 8'h09);
      doWrite(6'd17, 8'h01);
      doVblank();
      doWrite(6'd0, 8'h05);
      doWrite(6'd17, 8'h01);
      reg_addr = 6'd0; in_data = 8'h11; we = 1'b1; vblank = 1'b1;
      applyStimulus();
      we = 1'b0; vblank = 1'b0;
      checkOutput("race committed", committed, 1'b1);
      readCheck("race shadow x0", 6'd0, 8'h11);
      doDisp(0);
      checkOutput("race active x0", disp_x, 8'h05);
      checkOutput("race disp_y0", disp_y, 8'hA1);

      // work_done writes on vblank cycles
      doWrite(6'd17, 8'h01);
      reg_addr = 6'd17; in_data = 8'h00; we = 1'b1; vblank = 1'b1;
      applyStimulus();
      checkOutput("wd0 on commit committed", committed, 1'b1);
      readCheck("wd0 on commit pending", 6'd36, 8'h00);
      readCheck("frame_cnt 4", 6'd34, 8'h04);
      reg_addr = 6'd17; in_data = 8'h01; we = 1'b1; vblank = 1'b1;
      applyStimulus();
      we = 1'b0; vblank = 1'b0;
      checkOutput("wd1 on drop committed", committed, 1'b0);
      readCheck("wd1 on drop pending", 6'd36, 8'h01);
      readCheck("drop_cnt 2", 6'd35, 8'h02);
      checkRegs("directed");

      // Counter saturation and wrap
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      for (int i = 0; i < 255; i++) doVblank();
      readCheck("drop_cnt 255", 6'd35, 8'hFF);
      doVblank();
      readCheck("drop_cnt saturated", 6'd35, 8'hFF);
      for (int i = 0; i < 256; i++) begin
         doWrite(6'd17, 8'h01);
         doVblank();
         if (i == 254) readCheck("frame_cnt 255", 6'd34, 8'hFF);
      end
      readCheck("frame_cnt wrapped", 6'd34, 8'h00);
      readCheck("drop_cnt after commits", 6'd35, 8'hFF);

      // Out-of-range renderer index, and reset winning over vblank
      doWrite(6'd0, 8'h5A);
      doWrite(6'd1, 8'h6B);
      doWrite(6'd17, 8'h01);
      doVblank();
      doDisp(0);
      checkOutput("idx0 disp_x", disp_x, 8'h5A);
      doDisp(NS);
      checkOutput("idx oob valid", disp_valid, 1'b1);
      checkOutput("idx oob disp_x", disp_x, 8'h00);
      checkOutput("idx oob disp_y", disp_y, 8'h00);
      checkOutput("idx oob disp_rot", disp_rot, 8'h00);
      doDisp(7);
      checkOutput("idx 7 disp_x", disp_x, 8'h00);
      doVblank();
      doWrite(6'd17, 8'h01);
      reset = 1'b1; vblank = 1'b1;
      applyStimulus();
      reset = 1'b0; vblank = 1'b0;
      checkOutput("reset+vblank committed", committed, 1'b0);
      readCheck("reset+vblank frame", 6'd34, 8'h00);
      readCheck("reset+vblank drop", 6'd35, 8'h00);
      readCheck("reset+vblank pending", 6'd36, 8'h00);
      applyStimulus();
      checkOutput("after reset committed", committed, 1'b0);
      checkOutput("after reset map_x", map_x, 8'h00);

      // Randomized run against the model
      for (int c = 0; c < 1500; c++) begin
         reset     = ($urandom_range(0, 299) == 0);
         we        = $urandom_range(0, 1);
         reg_addr  = ($urandom_range(0, 7) == 0) ? 6'd17 : 6'($urandom_range(0, 63));
         in_data   = 8'($urandom);
         vblank    = ($urandom_range(0, 5) == 0);
         disp_req  = $urandom_range(0, 1);
         disp_idx  = IW'($urandom_range(0, 7));
         mapData   = $urandom_range(0, 1);
         playerRot = 2'($urandom_range(0, 3));
         #1;
         checkOutput($sformatf("rand %0d read %0d", c, reg_addr), out_data, expRead(reg_addr));
         applyStimulus();
         checkRegs($sformatf("rand %0d", c));
      end
      reset = 1'b0; we = 1'b0; vblank = 1'b0; disp_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
